// File: rtl/capture_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : capture_arb_pkg
// Brief    : Shared types, constants and helpers for capture_reg_arbiter.
//            Holds the arbiter state encoding, the pointer width helper and
//            the explicit-wrap pointer advance.
// Revision : 1.0 - initial release
// ============================================================================
package capture_arb_pkg;

    // Default geometry used when the top is instantiated without overrides.
    localparam int NUM_REQ_DEFAULT = 4;
    localparam int DATA_W_DEFAULT  = 8;

    // Arbiter states: IDLE (nothing held) and HOLD (a word is presented).
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    // Ceiling log2 with a floor of one bit so a pointer always has width.
    function automatic int calc_ptr_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Pointer advance past the winner. The wrap is an explicit compare so
    // requester counts that are not a power of two rotate correctly.
    function automatic int next_ptr(input int w, input int n);
        return (w == n - 1) ? 0 : w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_reg_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Returns the first set bit of
//            elig scanning from ptr upward with wrap to zero, as both an
//            index and a one-hot vector, plus an any-eligible flag.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [PTR_W-1:0]   ptr,
    output logic               any,
    output logic [PTR_W-1:0]   winner,
    output logic [NUM_REQ-1:0] winner_oh
);

    // Sum is one bit wider than the pointer so ptr+k never overflows
    // before the wrap compare.
    localparam logic [PTR_W:0] C_NUM_REQ = (PTR_W + 1)'(NUM_REQ);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    // Scan candidates ptr, ptr+1, ... with explicit wrap; first hit wins.
    always_comb begin
        any       = 1'b0;
        winner    = '0;
        winner_oh = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (w_sum >= C_NUM_REQ) begin
                w_sum = w_sum - C_NUM_REQ;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!any && elig[w_idx]) begin
                any              = 1'b1;
                winner           = w_idx;
                winner_oh[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/capture_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : capture_reg_arbiter
// Brief    : Shares one capture register among NUM_REQ requesters using
//            round-robin arbitration. The winner's word is registered and
//            presented on a valid/ready interface; the winner receives a
//            one-cycle registered grant pulse.
// Revision : 1.0 - initial release
// ============================================================================
module capture_reg_arbiter
    import capture_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int PTR_W = calc_ptr_w(NUM_REQ);

    arb_state_t          r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;

    logic [NUM_REQ-1:0]  w_elig;
    logic                w_any;
    logic [PTR_W-1:0]    w_winner;
    logic [NUM_REQ-1:0]  w_winner_oh;
    logic                w_slot_free;
    logic                w_cap;
    logic [PTR_W-1:0]    w_next_ptr;
    logic [DATA_W-1:0]   w_data [NUM_REQ];

    // Unpack the flat data bus into one word per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_data[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // A requester whose grant is visible this cycle is still holding req
    // high by protocol; masking it prevents a double grant for one word.
    assign w_elig = req & ~r_gnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .elig      (w_elig),
        .ptr       (r_ptr),
        .any       (w_any),
        .winner    (w_winner),
        .winner_oh (w_winner_oh)
    );

    // The register may be overwritten when empty or when its word is being
    // accepted this cycle, which gives back-to-back capture in HOLD.
    assign w_slot_free = (r_state == ST_IDLE) || out_ready;
    assign w_cap       = w_slot_free && w_any;
    assign w_next_ptr  = PTR_W'(next_ptr(int'(w_winner), NUM_REQ));

    // Arbiter state, pointer, grant pulse and capture register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cap) begin
                        r_out_data  <= w_data[w_winner];
                        r_out_valid <= 1'b1;
                        r_gnt       <= w_winner_oh;
                        r_ptr       <= w_next_ptr;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (w_cap) begin
                        r_out_data  <= w_data[w_winner];
                        r_out_valid <= 1'b1;
                        r_gnt       <= w_winner_oh;
                        r_ptr       <= w_next_ptr;
                        r_state     <= ST_HOLD;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_gnt       <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_capture_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_reg_arbiter
// Brief    : Self-checking bench for capture_reg_arbiter: directed scenarios
//            followed by randomized requester traffic against a behavioural
//            reference model; a second 3-requester instance covers wrap.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_capture_reg_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int N3 = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            out_ready;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            busy;

    logic [N3-1:0]    req3;
    logic [N3*DW-1:0] req_data3;
    logic             out_ready3;
    logic [N3-1:0]    gnt3;
    logic             out_valid3;
    logic [DW-1:0]    out_data3;
    logic             busy3;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_hold;
    int          m_ptr;
    bit [N-1:0]  m_gnt;
    bit          m_valid;
    bit [DW-1:0] m_data;
    logic [N-1:0] prev_gnt;

    capture_reg_arbiter #(.NUM_REQ(N), .DATA_W(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy)
    );

    capture_reg_arbiter #(.NUM_REQ(N3), .DATA_W(DW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .req_data(req_data3),
        .gnt(gnt3), .out_valid(out_valid3), .out_data(out_data3),
        .out_ready(out_ready3), .busy(busy3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_hold  = 1'b0;
        m_ptr   = 0;
        m_gnt   = '0;
        m_valid = 1'b0;
        m_data  = '0;
    endfunction

    // One clock edge of the arbiter described by its rules: round-robin
    // scan with modulo arithmetic, capture when the slot is free.
    function automatic void model_edge();
        bit [N-1:0] elig;
        int w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        elig = req & ~m_gnt;
        w = -1;
        if ((!m_hold || out_ready) && elig != '0) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        if (w >= 0) begin
            m_data   = req_data[w*DW +: DW];
            m_valid  = 1'b1;
            m_gnt    = '0;
            m_gnt[w] = 1'b1;
            m_ptr    = (w + 1) % N;
            m_hold   = 1'b1;
        end else begin
            m_gnt = '0;
            if (m_hold && out_ready) begin
                m_valid = 1'b0;
                m_hold  = 1'b0;
            end
        end
    endfunction

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    // Advance one clock, update the model, then compare away from the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("busy", 32'(busy), 32'(m_hold));
        chk("gnt_repeat", 32'(gnt & prev_gnt), 32'd0);
        prev_gnt = gnt;
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        req_data   = '0;
        out_ready  = 1'b1;
        req3       = '0;
        req_data3  = '0;
        out_ready3 = 1'b1;
        prev_gnt   = '0;
        model_reset();

        // Reset then idle
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        #2 rst_n = 1'b1;
        repeat (5) begin
            step();
            chk("idle_valid", 32'(out_valid), 32'd0);
        end

        // Single requester
        set_data(2, 8'hA5);
        req       = 4'b0100;
        out_ready = 1'b1;
        step();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'hA5);
        req = '0;
        step();
        chk("single_drop_gnt", 32'(gnt), 32'd0);
        chk("single_drop_valid", 32'(out_valid), 32'd0);

        // Round-robin fairness from ptr=0
        rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_data(i, DW'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            chk("rr_data", 32'(out_data), 32'(8'h10 + (k % 4)));
        end
        req = '0;
        step();

        // Backpressure
        set_data(2, 8'h3C);
        req       = 4'b0100;
        out_ready = 1'b0;
        step();
        chk("bp_cap_gnt", 32'(gnt), 32'h4);
        chk("bp_cap_data", 32'(out_data), 32'h3C);
        req = 4'b0011;
        set_data(0, 8'h41);
        set_data(1, 8'h42);
        repeat (6) begin
            step();
            chk("bp_hold_data", 32'(out_data), 32'h3C);
            chk("bp_hold_gnt", 32'(gnt), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_gnt", 32'(gnt), 32'h1);
        chk("bp_next_data", 32'(out_data), 32'h41);
        step();
        chk("bp_after_gnt", 32'(gnt), 32'h2);
        chk("bp_after_data", 32'(out_data), 32'h42);
        req = '0;
        step();

        // Randomized requesters obeying the hold-until-grant rule
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        set_data(i, DW'($urandom_range(0, 255)));
                    end
                end else if (m_gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else set_data(i, DW'($urandom_range(0, 255)));
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req       = '0;
        out_ready = 1'b1;
        step();
        step();

        // Reset mid-transfer
        set_data(0, 8'h66);
        set_data(1, 8'h77);
        req       = 4'b0011;
        out_ready = 1'b0;
        step();
        chk("mt_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mt_async_valid", 32'(out_valid), 32'd0);
        chk("mt_async_gnt", 32'(gnt), 32'd0);
        chk("mt_async_data", 32'(out_data), 32'd0);
        chk("mt_async_busy", 32'(busy), 32'd0);
        model_reset();
        prev_gnt = '0;
        step();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mt_regrant_gnt", 32'(gnt), 32'h1);
        chk("mt_regrant_data", 32'(out_data), 32'h66);
        req = 4'b0010;
        step();
        chk("mt_second_gnt", 32'(gnt), 32'h2);
        chk("mt_second_data", 32'(out_data), 32'h77);
        req = '0;
        step();

        // Wrap on the 3-requester instance
        req_data3 = {8'h33, 8'h22, 8'h11};
        req3      = 3'b010;
        step();
        chk("wrap_first_gnt", 32'(gnt3), 32'h2);
        chk("wrap_first_data", 32'(out_data3), 32'h22);
        req3 = 3'b011;
        step();
        chk("wrap_w0_gnt", 32'(gnt3), 32'h1);
        chk("wrap_w0_data", 32'(out_data3), 32'h11);
        step();
        chk("wrap_w1_gnt", 32'(gnt3), 32'h2);
        chk("wrap_w1_data", 32'(out_data3), 32'h22);
        req3 = '0;
        step();
        chk("wrap_drain_valid", 32'(out_valid3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
